// File: rtl/echo_capture_if.sv
// rtl/echo_capture_if.sv - arm/echo inputs and measurement result bundle for echo_capture
interface echo_capture_if;
    logic        start;
    logic        echo;
    logic [15:0] width_us;
    logic        valid;
    logic        timeout;
    logic        overrange;
    logic        busy;

    // Trigger side / sensor line driver and result consumer
    modport master (
        output start,
        output echo,
        input  width_us,
        input  valid,
        input  timeout,
        input  overrange,
        input  busy
    );

    // Capture block
    modport slave (
        input  start,
        input  echo,
        output width_us,
        output valid,
        output timeout,
        output overrange,
        output busy
    );
endinterface

// File: rtl/echo_capture.sv
// rtl/echo_capture.sv - ultrasonic echo pulse width capture in whole microseconds
module echo_capture #(
    parameter int CLK_PER_US = 50,
    parameter int TIMEOUT_US = 30000,
    parameter int MAX_US     = 25000
) (
    input  logic      clk,
    input  logic      rst,
    echo_capture_if.slave bus
);

    localparam int PRE_W   = $clog2(CLK_PER_US);
    localparam int LIM     = (TIMEOUT_US > MAX_US) ? TIMEOUT_US : MAX_US;
    localparam int CNT_W   = ($clog2(LIM + 1) > 16) ? $clog2(LIM + 1) : 16;

    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(CLK_PER_US - 1);
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT_US);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_US);
    localparam logic [15:0]      MAX_W   = 16'(MAX_US);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] pre;
    logic [CNT_W-1:0] cnt;

    logic             echo_m;
    logic             echo_s;
    logic             echo_prev;
    logic             rise;
    logic             fall;

    logic [15:0]      width_r;
    logic             valid_r;
    logic             timeout_r;
    logic             overrange_r;
    logic             busy_r;

    // Two-flop synchroniser for the raw echo line plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            echo_m    <= 1'b0;
            echo_s    <= 1'b0;
            echo_prev <= 1'b0;
        end else begin
            echo_m    <= bus.echo;
            echo_s    <= echo_m;
            echo_prev <= echo_s;
        end
    end

    assign rise = echo_s & ~echo_prev;
    assign fall = ~echo_s & echo_prev;

    // Measurement FSM: arm, wait for rising edge, time the high phase, report once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pre         <= '0;
            cnt         <= '0;
            width_r     <= '0;
            valid_r     <= 1'b0;
            timeout_r   <= 1'b0;
            overrange_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= WAIT_RISE;
                        busy_r <= 1'b1;
                        pre    <= '0;
                        cnt    <= '0;
                    end
                end
                WAIT_RISE: begin
                    if (rise) begin
                        // The detection cycle is already the first high cycle
                        state <= MEASURE;
                        pre   <= PRE_W'(1);
                        cnt   <= '0;
                    end else if (cnt == TO_CNT) begin
                        state       <= IDLE;
                        busy_r      <= 1'b0;
                        width_r     <= '0;
                        timeout_r   <= 1'b1;
                        overrange_r <= 1'b0;
                        valid_r     <= 1'b1;
                    end else if (pre == PRE_TOP) begin
                        pre <= '0;
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        pre <= pre + PRE_W'(1);
                    end
                end
                MEASURE: begin
                    // Overrange is tested first so it wins over a coincident fall
                    if (cnt == MAX_CNT) begin
                        state       <= WAIT_LOW;
                        width_r     <= MAX_W;
                        timeout_r   <= 1'b0;
                        overrange_r <= 1'b1;
                        valid_r     <= 1'b1;
                    end else if (fall) begin
                        state       <= IDLE;
                        busy_r      <= 1'b0;
                        width_r     <= cnt[15:0];
                        timeout_r   <= 1'b0;
                        overrange_r <= 1'b0;
                        valid_r     <= 1'b1;
                    end else if (pre == PRE_TOP) begin
                        pre <= '0;
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        pre <= pre + PRE_W'(1);
                    end
                end
                WAIT_LOW: begin
                    if (!echo_s) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.width_us  = width_r;
    assign bus.valid     = valid_r;
    assign bus.timeout   = timeout_r;
    assign bus.overrange = overrange_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_echo_capture.sv
// tb/tb_echo_capture.sv - scoreboard bench for echo_capture
module tb_echo_capture;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    echo_capture_if bus ();

    echo_capture #(
        .CLK_PER_US (50),
        .TIMEOUT_US (10),
        .MAX_US     (100)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int w;
        int to;
        int ovr;
        int lo;
        int hi;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic push_exp(input int w, input int to, input int ovr, input int lo, input int hi);
        exp_t x;
        x.w = w; x.to = to; x.ovr = ovr; x.lo = lo; x.hi = hi;
        sb.push_back(x);
    endtask

    // start, wait pre clocks, raw echo high for 'high' clocks; valid due 3 clk after the fall
    task automatic measure(input int pre, input int high, input int exp_w);
        pulse_start();
        tick(pre);
        bus.echo = 1'b1;
        tick(high);
        bus.echo = 1'b0;
        push_exp(exp_w, 0, 0, cyc + 3, cyc + 3);
        tick(10);
    endtask

    // Monitor: every valid pops one expected result
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: valid at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk("width_us", int'(bus.width_us), e.w);
                chk("timeout", int'(bus.timeout), e.to);
                chk("overrange", int'(bus.overrange), e.ovr);
                chk("busy_at_valid", int'(bus.busy), e.ovr);
                n_chk++;
                if (cyc < e.lo || cyc > e.hi) begin
                    n_fail++;
                    $display("FAIL valid_cycle: got %0d expected %0d..%0d", cyc, e.lo, e.hi);
                end
            end
        end
    end

    int c;

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.echo  = 1'b0;
        tick(3);
        chk("rst_width", int'(bus.width_us), 0);
        chk("rst_valid", int'(bus.valid), 0);
        chk("rst_timeout", int'(bus.timeout), 0);
        chk("rst_overrange", int'(bus.overrange), 0);
        chk("rst_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        tick(5);

        // Basic widths and truncation boundaries
        measure(200, 1000, 20);
        measure(20, 1049, 20);
        measure(20, 1050, 21);
        measure(20, 49, 0);

        // Timeout: start sampled at edge c+1, result 500 +/- 1 clk later
        c = cyc;
        pulse_start();
        chk("busy_armed", int'(bus.busy), 1);
        push_exp(0, 1, 0, c + 500, c + 502);
        tick(520);
        chk("busy_after_timeout", int'(bus.busy), 0);
        measure(100, 250, 5);

        // Overrange: 100 us reached after 5000 synced high cycles
        pulse_start();
        tick(10);
        bus.echo = 1'b1;
        c = cyc;
        push_exp(100, 0, 1, c + 5001, c + 5005);
        tick(6000);
        chk("busy_wait_low", int'(bus.busy), 1);
        tick(2000);
        bus.echo = 1'b0;
        tick(6);
        chk("busy_after_low", int'(bus.busy), 0);

        // Echo already high at arm time: only the later re-rise is measured
        bus.echo = 1'b1;
        tick(10);
        pulse_start();
        tick(300);
        bus.echo = 1'b0;
        tick(20);
        bus.echo = 1'b1;
        tick(500);
        bus.echo = 1'b0;
        push_exp(10, 0, 0, cyc + 3, cyc + 3);
        tick(10);

        // Start pulses during MEASURE and in the valid cycle are ignored
        pulse_start();
        tick(30);
        bus.echo = 1'b1;
        tick(100);
        pulse_start();
        tick(199);
        pulse_start();
        tick(299);
        bus.echo = 1'b0;
        push_exp(12, 0, 0, cyc + 3, cyc + 3);
        tick(2);
        pulse_start();
        tick(600);
        chk("busy_ignored_start", int'(bus.busy), 0);

        // Reset mid-MEASURE clears outputs immediately and yields no valid
        pulse_start();
        tick(10);
        bus.echo = 1'b1;
        tick(300);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_width", int'(bus.width_us), 0);
        chk("abort_valid", int'(bus.valid), 0);
        chk("abort_timeout", int'(bus.timeout), 0);
        chk("abort_overrange", int'(bus.overrange), 0);
        chk("abort_busy", int'(bus.busy), 0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        bus.echo = 1'b0;
        tick(50);
        chk("busy_after_abort", int'(bus.busy), 0);

        // Recovery after abort
        measure(10, 150, 3);

        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
